// File: rtl/load_store_unit_if.sv
// Word-wide data memory bus seen by the load/store unit.
// The LSU drives address/enables/data; memory returns a combinational read word.
interface load_store_unit_if;
  logic        o_mem_valid;
  logic        o_mem_read_enable;
  logic        o_mem_write_enable;
  logic [31:0] o_mem_address;
  logic [31:0] o_mem_write_data;
  logic [31:0] i_mem_read_data;

  modport master (
    output o_mem_valid,
    output o_mem_read_enable,
    output o_mem_write_enable,
    output o_mem_address,
    output o_mem_write_data,
    input  i_mem_read_data
  );

  modport slave (
    input  o_mem_valid,
    input  o_mem_read_enable,
    input  o_mem_write_enable,
    input  o_mem_address,
    input  o_mem_write_data,
    output i_mem_read_data
  );
endinterface

// File: rtl/load_store_unit.sv
// MEM-stage front end: sub-word lane select/extend and RMW sub-word stores.
// Optional LSU_MISALIGN_TRAP_EN suppresses misaligned accesses and pulses o_misaligned.
module load_store_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_valid,
  input  logic                  i_mem_read,
  input  logic                  i_mem_write,
  input  logic [1:0]            i_size,
  input  logic                  i_unsigned,
  input  logic [DATA_WIDTH-1:0] i_address,
  input  logic [DATA_WIDTH-1:0] i_store_data,
  load_store_unit_if.master     mem,
  output logic [31:0]           o_load_data,
  output logic                  o_load_valid,
  output logic                  o_stall,
  output logic                  o_misaligned
);

  typedef enum logic {IDLE, RMW_WRITE} state_e;

  state_e      state_q, state_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] load_data_q, load_data_d;
  logic        load_valid_q, load_valid_d;
  logic        misaligned_q, misaligned_d;

  logic        is_byte, is_half, is_word;
  logic        misalign;
  logic        rd_en, wr_en;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ext;
  logic [31:0] lane_mask;
  logic [31:0] lane_data;
  logic [31:0] merged;
  logic        unused_cfg;

  assign unused_cfg = (MEM_DEPTH == 0) ^ (DATA_WIDTH == 0);

  assign is_byte = (i_size == 2'b00);
  assign is_half = (i_size == 2'b01);
  assign is_word = i_size[1];

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = (is_half & i_address[0])
                  | (is_word & (|i_address[1:0]));
`else
  assign misalign = 1'b0;
`endif

  assign rdata    = mem.i_mem_read_data;
  assign shifted  = rdata >> {i_address[1:0], 3'b000};
  assign byte_sel = shifted[7:0];
  assign half_sel = i_address[1] ? rdata[31:16] : rdata[15:0];

  // Pick the load lane and sign/zero extend it
  always_comb begin
    ext       = rdata;
    lane_mask = 32'hFFFF_FFFF;
    lane_data = i_store_data;
    unique case (1'b1)
      is_byte: begin
        ext       = {{24{~i_unsigned & byte_sel[7]}}, byte_sel};
        lane_mask = 32'h0000_00FF << {i_address[1:0], 3'b000};
        lane_data = {4{i_store_data[7:0]}};
      end
      is_half: begin
        ext       = {{16{~i_unsigned & half_sel[15]}}, half_sel};
        lane_mask = i_address[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
        lane_data = {2{i_store_data[15:0]}};
      end
      default: begin
        ext       = rdata;
        lane_mask = 32'hFFFF_FFFF;
        lane_data = i_store_data;
      end
    endcase
  end

  assign merged = (rdata & ~lane_mask) | (lane_data & lane_mask);

  // Next-state, memory enables and registered-output updates
  always_comb begin
    state_d      = state_q;
    merge_d      = merge_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    misaligned_d = 1'b0;
    rd_en        = 1'b0;
    wr_en        = 1'b0;
    wdata        = i_store_data;
    o_stall      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_valid) begin
          if (misalign & (i_mem_read | i_mem_write)) begin
            misaligned_d = 1'b1;
          end else if (i_mem_write) begin
            if (is_word) begin
              wr_en = 1'b1;
            end else begin
              rd_en   = 1'b1;
              o_stall = 1'b1;
              merge_d = merged;
              state_d = RMW_WRITE;
            end
          end else if (i_mem_read) begin
            rd_en        = 1'b1;
            load_data_d  = ext;
            load_valid_d = 1'b1;
          end
        end
      end
      RMW_WRITE: begin
        wr_en   = 1'b1;
        wdata   = merge_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= IDLE;
      merge_q      <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      merge_q      <= merge_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign mem.o_mem_read_enable  = rd_en;
  assign mem.o_mem_write_enable = wr_en & ~i_reset;
  assign mem.o_mem_valid        = rd_en | (wr_en & ~i_reset);
  assign mem.o_mem_address      = {2'b00, i_address[31:2]};
  assign mem.o_mem_write_data   = wdata;

  assign o_load_data  = load_data_q;
  assign o_load_valid = load_valid_q;
  assign o_misaligned = misaligned_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array reference memory, load scoreboard,
// directed cases plus randomized loads/stores.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        i_valid;
  logic        i_mem_read;
  logic        i_mem_write;
  logic [1:0]  i_size;
  logic        i_unsigned;
  logic [31:0] i_address;
  logic [31:0] i_store_data;
  logic [31:0] o_load_data;
  logic        o_load_valid;
  logic        o_stall;
  logic        o_misaligned;

  load_store_unit_if bus ();

  load_store_unit #(.DATA_WIDTH(32), .MEM_DEPTH(1024)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_valid      (i_valid),
    .i_mem_read   (i_mem_read),
    .i_mem_write  (i_mem_write),
    .i_size       (i_size),
    .i_unsigned   (i_unsigned),
    .i_address    (i_address),
    .i_store_data (i_store_data),
    .mem          (bus),
    .o_load_data  (o_load_data),
    .o_load_valid (o_load_valid),
    .o_stall      (o_stall),
    .o_misaligned (o_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [64];
  always @(negedge clk)
    if (bus.o_mem_write_enable)
      mem[bus.o_mem_address[5:0]] <= bus.o_mem_write_data;
  assign bus.i_mem_read_data = mem[bus.o_mem_address[5:0]];

  logic [7:0]  ref_b [256];
  logic [31:0] exp_q [$];
  int          checks = 0;
  int          failures = 0;
  bit          prev_mis = 0;

  function void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (o_load_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL load_unexpected actual=%h expected=none", o_load_data);
      end else begin
        check("load_data", o_load_data, exp_q.pop_front());
      end
    end
  end

  task automatic issue(input bit v, input bit rd, input bit wr,
                       input logic [1:0] sz, input bit uns,
                       input logic [7:0] a, input logic [31:0] d);
    int      nb;
    int      eff;
    bit      mis;
    bit      sub;
    longint  val;
    i_valid      = v;
    i_mem_read   = rd;
    i_mem_write  = wr;
    i_size       = sz;
    i_unsigned   = uns;
    i_address    = {24'b0, a};
    i_store_data = d;
    nb  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    mis = 0;
`ifdef LSU_MISALIGN_TRAP_EN
    mis = v && (rd || wr) && ((int'(a) % nb) != 0);
`endif
    eff = int'(a) - (int'(a) % nb);
    sub = v && wr && !mis && (nb < 4);
    if (v && !mis) begin
      if (wr) begin
        for (int k = 0; k < nb; k++)
          ref_b[eff + k] = 8'((d >> (8 * k)) & 32'hFF);
      end else if (rd) begin
        val = 0;
        for (int k = 0; k < nb; k++)
          val = val | (longint'(ref_b[eff + k]) << (8 * k));
        if (!uns && val[8 * nb - 1])
          val = val - (longint'(1) << (8 * nb));
        exp_q.push_back(val[31:0]);
      end
    end
    @(negedge clk);
    check("stall", {31'b0, o_stall}, {31'b0, sub});
    check("misaligned", {31'b0, o_misaligned}, {31'b0, prev_mis});
    check("mem_valid", {31'b0, bus.o_mem_valid},
          {31'b0, v && (rd || wr) && !mis});
    prev_mis = mis;
    if (sub) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      check("rmw_stall", {31'b0, o_stall}, 32'd0);
      check("rmw_we", {31'b0, bus.o_mem_write_enable}, 32'd1);
      check("misaligned", {31'b0, o_misaligned}, {31'b0, prev_mis});
      prev_mis = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    rst = 1'b1;
    i_valid = 0; i_mem_read = 0; i_mem_write = 0;
    i_size = 0; i_unsigned = 0; i_address = 0; i_store_data = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_load_data", o_load_data, 32'd0);
    check("rst_load_valid", {31'b0, o_load_valid}, 32'd0);
    check("rst_misaligned", {31'b0, o_misaligned}, 32'd0);
    check("rst_stall", {31'b0, o_stall}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 64; i++)
      issue(1, 0, 1, 2'b10, 0, 8'(i * 4), $urandom);

    issue(1, 0, 1, 2'b10, 0, 8'h08, 32'h1122_3344);
    issue(1, 1, 0, 2'b00, 0, 8'h0B, 0);
    issue(1, 0, 1, 2'b10, 0, 8'h08, 32'h8000_1234);
    issue(1, 1, 0, 2'b01, 0, 8'h08, 0);
    issue(1, 1, 0, 2'b01, 0, 8'h0A, 0);
    issue(1, 0, 1, 2'b10, 0, 8'h08, 32'h1122_3344);
    issue(1, 0, 1, 2'b00, 0, 8'h09, 32'h0000_00AB);
    issue(1, 1, 0, 2'b10, 0, 8'h08, 0);
    issue(1, 0, 1, 2'b10, 0, 8'h10, 32'hDEAD_BEEF);
    issue(1, 1, 0, 2'b10, 0, 8'h10, 0);
    issue(1, 0, 1, 2'b01, 0, 8'h05, 32'h0000_C3D2);
    issue(1, 1, 0, 2'b01, 1, 8'h06, 0);
    issue(1, 1, 0, 2'b10, 0, 8'h06, 0);
    issue(1, 1, 1, 2'b00, 0, 8'h22, 32'h0000_0077);
    issue(1, 1, 0, 2'b11, 0, 8'h20, 0);

    i_valid = 1; i_mem_read = 0; i_mem_write = 1;
    i_size = 2'b01; i_unsigned = 0; i_address = 32'h4;
    i_store_data = 32'h0000_5A5A;
    @(negedge clk);
    check("rst_rmw_stall", {31'b0, o_stall}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_rmw_we", {31'b0, bus.o_mem_write_enable}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    i_valid = 0;
    prev_mis = 0;
    @(negedge clk);
    check("rst_rmw_load_data", o_load_data, 32'd0);
    check("rst_rmw_load_valid", {31'b0, o_load_valid}, 32'd0);
    check("rst_rmw_stall_idle", {31'b0, o_stall}, 32'd0);
    check("rst_rmw_misaligned", {31'b0, o_misaligned}, 32'd0);
    @(posedge clk);
    #1;
    issue(0, 0, 1, 2'b00, 0, 8'h04, 0);
    issue(1, 1, 0, 2'b10, 0, 8'h04, 0);

    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0)
        issue(0, 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
              8'($urandom), $urandom);
      else if (r <= 4)
        issue(1, 1, 0, 2'($urandom), 1'($urandom), 8'($urandom), 0);
      else if (r <= 8)
        issue(1, 0, 1, 2'($urandom), 1'($urandom), 8'($urandom), $urandom);
      else
        issue(1, 1, 1, 2'($urandom), 1'($urandom), 8'($urandom), $urandom);
    end

    i_valid = 0;
    @(negedge clk);
    for (int i = 0; i < 64; i++) begin
      w = {ref_b[4*i+3], ref_b[4*i+2], ref_b[4*i+1], ref_b[4*i]};
      check("mem_word", mem[i], w);
    end
    check("load_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage front end for the pipelined MIPS datapath. Sits between the EX/MEM pipeline register and the word-wide data memory. Converts byte, halfword and word loads/stores into word-addressed memory accesses: little-endian lane selection, sign/zero extension, and a two-cycle read-modify-write for sub-word stores. Loads are returned in a registered output that feeds the MEM/WB register, and a stall is raised toward the pipeline during read-modify-write.

## Interface
Parameters:
- DATA_WIDTH, 32, data and byte-address width; fixed at 32 for lane logic.
- MEM_DEPTH, 1024, data memory entries (words); word address = byte address [31:2].

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_valid  in  1  EX/MEM slot holds a live instruction.
- i_mem_read  in  1  load request.
- i_mem_write  in  1  store request.
- i_size  in  2  00 byte, 01 halfword, 10 word; 11 treated as word.
- i_unsigned  in  1  loads: 1 zero-extend, 0 sign-extend.
- i_address  in  32  byte address.
- i_store_data  in  32  store operand; sub-word data in low bits.
- i_mem_read_data  in  32  word from data memory (combinational read).
- o_mem_valid  out  1  drives memory i_valid.
- o_mem_read_enable  out  1  memory read enable.
- o_mem_write_enable  out  1  memory write enable (memory writes on falling edge).
- o_mem_address  out  32  word address, {2'b00, i_address[31:2]}.
- o_mem_write_data  out  32  word to write.
- o_load_data  out  32  registered, extended load result.
- o_load_valid  out  1  registered; o_load_data is new this cycle.
- o_stall  out  1  combinational; hold EX/MEM and earlier stages.
- o_misaligned  out  1  registered one-cycle pulse (see Configuration).

## Operation
- States: IDLE, RMW_WRITE.
- IDLE, load (i_valid & i_mem_read & !i_mem_write): read enable high; lane = address[1:0] (byte) or address[1] (half). Extended result and o_load_valid=1 are registered at the next edge.
- IDLE, word store: write enable high, write data = i_store_data; completes in one cycle, no stall.
- IDLE, byte/half store: read enable high, o_stall=1. Merge i_store_data lanes into i_mem_read_data and register the result in merge_q. Next state RMW_WRITE.
- RMW_WRITE: write enable high, write data = merge_q, o_stall=0, read enable low. Upstream inputs still hold the same store and are consumed; next state IDLE.
- Read and write both asserted: treated as a store; no load result.
- i_valid=0: all memory enables low; o_load_valid=0 next cycle; o_load_data holds its value.
- Lane mapping: byte n occupies bits [8n+7:8n]. Halfword 0 is [15:0], halfword 1 is [31:16].

## Timing
- Reset values: state IDLE, o_load_data 0, o_load_valid 0, o_misaligned 0, merge_q 0.
- Load latency: 1 cycle (request cycle N → o_load_data valid in cycle N+1).
- Word store: 1 cycle. Sub-word store: 2 cycles, with o_stall high in the first cycle only.
- o_mem_write_enable is gated by !i_reset, so no write occurs in a cycle with reset asserted. Reset in RMW_WRITE drops the pending write and returns to IDLE.
- Back-to-back sub-word stores: stall pattern 1,0,1,0; each store writes exactly once.
- A load directly after a store to the same word sees the new data, because the falling-edge write precedes the next cycle's combinational read.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - A halfword with address[0]=1, or a word with address[1:0]≠0, suppresses all memory enables.
  - No state change and no load valid.
  - o_misaligned pulses high the next cycle.
- LSU_MISALIGN_TRAP_EN undefined:
  - Low address bits are ignored for that size (halfword uses address[1], word uses the whole word).
  - The access proceeds normally; o_misaligned is constant 0.

## Test plan
- Memory word 0x11223344 at byte address 8; lb address 0x0B signed → o_load_data 0x00000011. lh address 0x08 signed on 0x8000xxxx-type data 0x80001234 lower half → 0x00001234; upper half (address 0x0A) → 0xFFFF8000.
- sb 0xAB to address 0x09 on 0x11223344 → o_stall 1 for one cycle, then written word 0x1122AB44; later lw returns 0x1122AB44.
- Word store 0xDEADBEEF to address 0x10, lw address 0x10 in the next cycle → 0xDEADBEEF, no stall in either cycle.
- sh to address 0x04 with i_reset asserted during RMW_WRITE → memory word unchanged; state IDLE; all outputs at reset values.
- With LSU_MISALIGN_TRAP_EN, lw address 0x06 → no enables asserted, o_misaligned=1 for one cycle, o_load_valid=0. Without the macro, the same access returns the word at 0x04.
